env_vca32: RTL
==============

Name: env_vca32

Overview:
Envelope-controlled amplifier stage directly downstream of adsr32. Takes the 32-bit envelope accumulator (adsr32 sout) and scales a signed 16-bit oscillator sample stream by it. Uses a valid/ready handshake on both sides, has a 2-stage pipeline, and raises a voice-idle flag for the voice allocator once the envelope has stayed at zero.

Parameters:
SLEW, 16'h0100, max change of the applied gain per accepted sample (Q0.16 units; used only with ENV_SLEW_EN).
IDLE_SAMPLES, 64, consecutive accepted zero-gain samples before voice_idle asserts (1..65535).

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-high
env_in  in  32  envelope level from adsr32 sout, unsigned
smp_in  in  16  signed oscillator sample, two's complement
smp_valid  in  1  smp_in valid
smp_ready  out  1  stage can accept smp_in this cycle
out_sample  out  16  signed scaled sample
out_valid  out  1  out_sample valid
out_ready  in  1  downstream accepts out_sample
voice_idle  out  1  envelope silent for IDLE_SAMPLES accepted samples

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on rst.
- Reset values: out_sample=0, out_valid=0, voice_idle=1, applied gain g=0, idle counter=0. All pipeline valid bits are cleared.
- Target gain: tgt = env_in[31:16], unsigned Q0.16, so 16'hFFFF ≈ 1.0. Bits [15:0] are ignored.
- Handshake:
  - Accept when smp_valid && smp_ready. Pipeline stall is global.
  - smp_ready = !(s2_valid && !out_ready).
  - out_valid = s2_valid. out_sample is held stable while out_valid && !out_ready.
- Latency: a sample accepted at cycle N appears at out_valid in cycle N+2 if no stall occurs. Throughput is 1 sample/cycle.
- Stage 1 (on accept):
  - Update g: without the feature, g <= tgt. With the feature, see Optional Feature.
  - Compute p = smp_in * {1'b0, g_new}, signed 16x17 -> 33 bits.
  - Register p and s1_valid.
- Stage 2:
  - out_sample <= (p + 2^15) >>> 16, truncated to 16 bits (round half up).
  - The range is provably within [-32767, 32767], so no saturation logic is needed.
  - -32768*0xFFFF rounds to -32767.
- Idle counter, advanced on each accept:
  - If g_new == 0, the counter increments, saturating at IDLE_SAMPLES.
  - Otherwise the counter clears to 0 and voice_idle drops in the next cycle.
  - voice_idle = (counter == IDLE_SAMPLES).
- Simultaneous events: stage 2 can drain while stage 1 accepts in the same cycle; the pipeline advances normally.
- When not accepting: g and the idle counter hold their values. env_in changes are ignored until the next accept.
- rst mid-stream: all in-flight samples are discarded and outputs return to reset values on the next edge. Any out_ready state is irrelevant.

Optional Feature:
Macro ENV_SLEW_EN.
- Defined: per accept, g_new moves toward tgt by at most SLEW:
  - |tgt-g| <= SLEW -> g_new=tgt.
  - Otherwise g_new = g±SLEW, computed without wrap.
  - This removes zipper noise when the envelope jumps.
- Undefined: g_new = tgt directly, and SLEW is unused.

Decomposition:
- Package synth_pkg:
  - SMP_W=16, ENV_W=32, GAIN_W=16 constants.
  - typedef smp_t (signed [15:0]).
  - typedef gain_t ([15:0]).
- One sub-module is natural: gain_slew (g register plus slew clamp logic). It is instantiated only under ENV_SLEW_EN; otherwise a plain register is used.

Test Plan:
1. Passthrough: env_in=32'hFFFF_0000, smp_in=16'h4000, out_ready=1 -> out_sample=16'h4000 two cycles after accept (0x4000*0xFFFF/2^16 rounds to 0x4000).
2. Half gain and rounding: env_in=32'h8000_0000, smp_in=-3 -> -1 (-1.5 rounds half up). smp_in=3 -> 2.
3. Backpressure: stream 0..7 with out_ready low for 3 cycles mid-burst -> smp_ready=0 while stalled, out_sample held stable, no loss or duplication, order preserved.
4. Idle: env_in=0, IDLE_SAMPLES=4, 4 accepts -> voice_idle=1 after the 4th. Then env_in=32'h0001_0000 and one accept -> voice_idle=0.
5. Slew (ENV_SLEW_EN, SLEW=16'h0100): g=0, env_in jumps to 32'hFFFF_0000 -> g steps 0x0100, 0x0200, … per accept, reaching 0xFFFF on accept 256. Without the macro, g=0xFFFF on the first accept.
6. Reset mid-stream: assert rst with both stages valid -> next cycle out_valid=0, out_sample=0, voice_idle=1, and the first post-reset accept uses g starting from 0.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared widths, sample/gain types and the Q0.16 rounding helper for the envelope VCA.
package synth_pkg;

    localparam int unsigned SMP_W  = 16;
    localparam int unsigned ENV_W  = 32;
    localparam int unsigned GAIN_W = 16;

    typedef logic signed [SMP_W-1:0] smp_t;
    typedef logic [GAIN_W-1:0]       gain_t;

    // Round half up, then drop the 16 fractional bits; the range never exceeds +/-32767.
    function automatic smp_t round_q16(input logic signed [32:0] p);
        logic signed [32:0] r;
        r = p + 33'sd32768;
        return smp_t'(r[31:16]);
    endfunction

endpackage

// File: rtl/env_vca32_gain_slew.sv
// Applied-gain register that moves toward the target by at most SLEW per accepted sample.
module gain_slew
    import synth_pkg::*;
#(
    parameter gain_t SLEW = 16'h0100
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    input  gain_t tgt_i,
    output gain_t g_new_o
);

    gain_t g_q;

    // Differences are taken only in the direction that cannot wrap.
    always_comb begin
        g_new_o = tgt_i;
        if (tgt_i > g_q && (tgt_i - g_q) > SLEW) begin
            g_new_o = g_q + SLEW;
        end else if (tgt_i < g_q && (g_q - tgt_i) > SLEW) begin
            g_new_o = g_q - SLEW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q <= '0;
        end else if (en_i) begin
            g_q <= g_new_o;
        end
    end

endmodule

// File: rtl/env_vca32.sv
// Envelope-controlled amplifier: 2-stage valid/ready pipeline scaling samples by env_in[31:16].
// Optional gain slew limiting is enabled by defining ENV_SLEW_EN.
module env_vca32
    import synth_pkg::*;
#(
    parameter gain_t       SLEW         = 16'h0100,
    parameter int unsigned IDLE_SAMPLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ENV_W-1:0] env_in,
    input  logic [SMP_W-1:0] smp_in,
    input  logic             smp_valid,
    output logic             smp_ready,
    output logic [SMP_W-1:0] out_sample,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             voice_idle
);

    localparam logic [15:0] IdleMax = 16'(IDLE_SAMPLES);

    gain_t              tgt;
    gain_t              g_new;
    logic               accept;
    logic signed [32:0] p_d, p_q;
    logic               s1_valid_q, s2_valid_q;
    smp_t               out_sample_q;
    logic [15:0]        idle_cnt_d, idle_cnt_q;
    logic               voice_idle_q;
    logic [15:0]        unused_env_frac;

    assign tgt             = env_in[ENV_W-1:ENV_W-GAIN_W];
    assign unused_env_frac = env_in[15:0];

    // The whole pipeline stalls together whenever the output stage is blocked.
    assign smp_ready = !(s2_valid_q && !out_ready);
    assign accept    = smp_valid && smp_ready;

`ifdef ENV_SLEW_EN
    gain_slew #(
        .SLEW(SLEW)
    ) u_gain_slew (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept),
        .tgt_i  (tgt),
        .g_new_o(g_new)
    );
`else
    // Without slew limiting the applied gain is simply the target latched on each accept.
    logic [GAIN_W-1:0] unused_slew;
    assign unused_slew = SLEW;
    assign g_new       = tgt;
`endif

    assign p_d = 33'($signed(smp_in)) * 33'($signed({1'b0, g_new}));

    always_comb begin
        idle_cnt_d = '0;
        if (g_new == '0) begin
            idle_cnt_d = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            p_q          <= '0;
            out_sample_q <= '0;
            idle_cnt_q   <= '0;
            voice_idle_q <= 1'b1;
        end else if (smp_ready) begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            if (accept) begin
                p_q          <= p_d;
                idle_cnt_q   <= idle_cnt_d;
                voice_idle_q <= (idle_cnt_d == IdleMax);
            end
            if (s1_valid_q) begin
                out_sample_q <= round_q16(p_q);
            end
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = s2_valid_q;
    assign voice_idle = voice_idle_q;

endmodule
